// File: rtl/hazard_detection_unit.sv
// ============================================================================
// hazard_detection_unit: MEM-stage tracking, EX forwarding select, dmem wait FSM
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_detection_unit #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ex_valid,
  input  logic       ex_flush,
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic       ex_uses_rs1,
  input  logic       ex_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_reg_write,
  input  logic [6:0] ex_opcode,
  input  logic       dmem_ready,
  output logic [1:0] hazard_op,
  output logic [6:0] MEM_opcode,
  output logic [4:0] mem_rd,
  output logic       stall_pipeline,
  output logic [15:0] stall_count,
  output logic       mem_timeout
);

  localparam logic [6:0]  OP_NOP    = 7'b0010011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYCLES);

  if (XLEN < 1 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("hazard_detection_unit: illegal parameter value");
  end

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  logic        mem_valid_q, mem_valid_d;
  logic [4:0]  mem_rd_q, mem_rd_d;
  logic        mem_reg_write_q, mem_reg_write_d;
  logic [6:0]  mem_opcode_q, mem_opcode_d;
  state_e      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_count_q, stall_count_d;
  logic        mem_timeout_q, mem_timeout_d;

  logic prod;
  logic memop;
  logic ex_live;

  always_comb begin
    prod    = mem_valid_q & mem_reg_write_q & (mem_rd_q != 5'd0);
    memop   = mem_valid_q & ((mem_opcode_q == OP_LOAD) | (mem_opcode_q == OP_STORE));
    ex_live = ex_valid & ~ex_flush;

    hazard_op[0] = prod & ex_valid & ex_uses_rs1 & (ex_rs1 == mem_rd_q);
    hazard_op[1] = prod & ex_valid & ex_uses_rs2 & (ex_rs2 == mem_rd_q);

    // WAIT is only ever entered with a memory op held in MEM, so ~dmem_ready suffices there
    if (state_q == ST_WAIT) stall_pipeline = ~dmem_ready;
    else                    stall_pipeline = memop & ~dmem_ready;

    mem_valid_d     = mem_valid_q;
    mem_rd_d        = mem_rd_q;
    mem_reg_write_d = mem_reg_write_q;
    mem_opcode_d    = mem_opcode_q;
    if (!stall_pipeline) begin
      mem_valid_d     = ex_live;
      mem_rd_d        = ex_rd;
      mem_reg_write_d = ex_live & ex_reg_write;
      mem_opcode_d    = ex_live ? ex_opcode : OP_NOP;
    end

    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (stall_pipeline) begin
          state_d    = ST_WAIT;
          wait_cnt_d = 16'd1;
        end
      end
      ST_WAIT: begin
        if (dmem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = 16'd0;
        end else if (wait_cnt_q != 16'hFFFF) begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = 16'd0;
      end
    endcase

    mem_timeout_d = mem_timeout_q | (stall_pipeline & (wait_cnt_d >= TIMEOUT_W));

    stall_count_d = stall_count_q;
    if (stall_pipeline && stall_count_q != 16'hFFFF) stall_count_d = stall_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_valid_q     <= 1'b0;
      mem_rd_q        <= 5'd0;
      mem_reg_write_q <= 1'b0;
      mem_opcode_q    <= OP_NOP;
      state_q         <= ST_RUN;
      wait_cnt_q      <= 16'd0;
      stall_count_q   <= 16'd0;
      mem_timeout_q   <= 1'b0;
    end else begin
      mem_valid_q     <= mem_valid_d;
      mem_rd_q        <= mem_rd_d;
      mem_reg_write_q <= mem_reg_write_d;
      mem_opcode_q    <= mem_opcode_d;
      state_q         <= state_d;
      wait_cnt_q      <= wait_cnt_d;
      stall_count_q   <= stall_count_d;
      mem_timeout_q   <= mem_timeout_d;
    end
  end

  assign MEM_opcode  = mem_opcode_q;
  assign mem_rd      = mem_rd_q;
  assign stall_count = stall_count_q;
  assign mem_timeout = mem_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_detection_unit.sv
// ============================================================================
// tb_hazard_detection_unit: vector table, directed stall sequences, random model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hazard_detection_unit;

  localparam int T_OUT = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ex_valid, ex_flush, ex_uses_rs1, ex_uses_rs2, ex_reg_write, dmem_ready;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [6:0]  ex_opcode;
  logic [1:0]  hazard_op;
  logic [6:0]  MEM_opcode;
  logic [4:0]  mem_rd;
  logic        stall_pipeline;
  logic [15:0] stall_count;
  logic        mem_timeout;

  int checks = 0;
  int errors = 0;

  hazard_detection_unit #(.XLEN(32), .TIMEOUT_CYCLES(T_OUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_flush(ex_flush),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_uses_rs1(ex_uses_rs1), .ex_uses_rs2(ex_uses_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_opcode(ex_opcode),
    .dmem_ready(dmem_ready),
    .hazard_op(hazard_op), .MEM_opcode(MEM_opcode), .mem_rd(mem_rd),
    .stall_pipeline(stall_pipeline), .stall_count(stall_count), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v, fl;
    logic [4:0] r1, r2;
    logic       a1, a2;
    logic [4:0] d;
    logic       w;
    logic [6:0] op;
    logic       rdy;
    logic [1:0] e_hz;
    logic       e_st;
    logic [6:0] e_mop;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic fl, input logic [4:0] r1, input logic [4:0] r2,
                       input logic a1, input logic a2, input logic [4:0] d, input logic w,
                       input logic [6:0] op, input logic rdy);
    ex_valid = v; ex_flush = fl; ex_rs1 = r1; ex_rs2 = r2;
    ex_uses_rs1 = a1; ex_uses_rs2 = a2; ex_rd = d; ex_reg_write = w;
    ex_opcode = op; dmem_ready = rdy;
  endtask

  task automatic idle(input logic rdy);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 7'h33, rdy);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive($urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, 7'($urandom), $urandom);
      tick();
      chk("reset hazard_op", 32'(hazard_op), 0);
      chk("reset stall", 32'(stall_pipeline), 0);
    end
    chk("reset stall_count", 32'(stall_count), 0);
    chk("reset MEM_opcode", 32'(MEM_opcode), 32'h13);
    chk("reset timeout", 32'(mem_timeout), 0);
    idle(1);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    logic [6:0] ops[5];
    // reference model state: the instruction sitting in MEM and the stall bookkeeping
    logic       m_valid, m_rw;
    logic [4:0] m_rd;
    logic [6:0] m_op;
    int         consec, scount;
    logic       m_to;

    vecs[0] = '{1, 0, 1, 2, 1, 1,  5, 1, 7'h33, 1, 2'b00, 0, 7'h13}; // add x5 into an empty MEM
    vecs[1] = '{1, 0, 5, 5, 1, 1,  6, 1, 7'h33, 1, 2'b11, 0, 7'h33}; // sub x6, x5, x5
    vecs[2] = '{1, 0, 6, 7, 1, 1,  0, 1, 7'h33, 1, 2'b01, 0, 7'h33}; // reads x6, writes x0
    vecs[3] = '{1, 1, 0, 0, 1, 1,  9, 1, 7'h33, 1, 2'b00, 0, 7'h33}; // x0 producer; flushed
    vecs[4] = '{1, 0, 9, 9, 1, 1, 10, 0, 7'h33, 1, 2'b00, 0, 7'h13}; // flushed x9 producer
    vecs[5] = '{1, 0, 3, 3, 0, 1,  3, 1, 7'h33, 0, 2'b00, 0, 7'h33}; // MEM rw=0, ready low, no memop

    do_reset();

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].fl, vecs[i].r1, vecs[i].r2, vecs[i].a1, vecs[i].a2,
            vecs[i].d, vecs[i].w, vecs[i].op, vecs[i].rdy);
      #3;
      chk($sformatf("vec%0d hazard_op", i), 32'(hazard_op), 32'(vecs[i].e_hz));
      chk($sformatf("vec%0d stall", i), 32'(stall_pipeline), 32'(vecs[i].e_st));
      chk($sformatf("vec%0d MEM_opcode", i), 32'(MEM_opcode), 32'(vecs[i].e_mop));
      tick();
    end

    // load x7 waits three cycles; dependent add in EX keeps seeing the forward
    drive(1, 0, 1, 0, 1, 0, 7, 1, 7'h03, 1);
    #3;
    chk("load issue stall", 32'(stall_pipeline), 0);
    chk("load issue stall_count", 32'(stall_count), 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 7, 8, 1, 1, 11, 1, 7'h33, (i == 3));
      #3;
      chk($sformatf("load wait%0d stall", i), 32'(stall_pipeline), (i == 3) ? 0 : 1);
      chk($sformatf("load wait%0d hazard_op", i), 32'(hazard_op), 32'b01);
      chk($sformatf("load wait%0d MEM_opcode", i), 32'(MEM_opcode), 32'h03);
      chk($sformatf("load wait%0d mem_rd", i), 32'(mem_rd), 7);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 7'h23, 0);
    #3;
    chk("after load stall", 32'(stall_pipeline), 0);
    chk("after load stall_count", 32'(stall_count), 3);
    chk("after load MEM_opcode", 32'(MEM_opcode), 32'h33);
    tick();
    idle(1);
    #3;
    chk("store ready-first stall", 32'(stall_pipeline), 0);
    chk("store MEM_opcode", 32'(MEM_opcode), 32'h23);
    tick();
    idle(0);
    #3;
    chk("store zero-cost stall_count", 32'(stall_count), 3);
    chk("store zero-cost stall", 32'(stall_pipeline), 0);
    tick();

    // randomized run against the model
    do_reset();
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63};
    m_valid = 0; m_rw = 0; m_rd = 0; m_op = 7'h13;
    consec = 0; scount = 0; m_to = 0;
    for (int c = 0; c < 600; c++) begin
      logic memop_e, stall_e;
      logic [1:0] hz_e;
      drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom, $urandom, 5'($urandom_range(0, 3)), $urandom,
            ops[$urandom_range(0, 4)], ($urandom_range(0, 3) != 0));
      #3;
      memop_e = m_valid && (m_op == 7'h03 || m_op == 7'h23);
      stall_e = memop_e && !dmem_ready;
      hz_e[0] = m_valid && m_rw && m_rd != 0 && ex_valid && ex_uses_rs1 && ex_rs1 == m_rd;
      hz_e[1] = m_valid && m_rw && m_rd != 0 && ex_valid && ex_uses_rs2 && ex_rs2 == m_rd;
      chk("rand hazard_op", 32'(hazard_op), 32'(hz_e));
      chk("rand stall", 32'(stall_pipeline), 32'(stall_e));
      chk("rand MEM_opcode", 32'(MEM_opcode), 32'(m_op));
      chk("rand mem_rd", 32'(mem_rd), 32'(m_rd));
      chk("rand stall_count", 32'(stall_count), scount);
      chk("rand timeout", 32'(mem_timeout), 32'(m_to));
      if (stall_e) begin
        consec++;
        if (consec >= T_OUT) m_to = 1;
        if (scount < 65535) scount++;
      end else begin
        consec  = 0;
        m_valid = ex_valid && !ex_flush;
        m_rw    = m_valid && ex_reg_write;
        m_rd    = ex_rd;
        m_op    = m_valid ? ex_opcode : 7'h13;
      end
      tick();
    end

    // timeout: ready never comes for the load, then finally arrives
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 4, 1, 7'h03, 1);
    tick();
    for (int i = 0; i < T_OUT; i++) begin
      idle(0);
      #3;
      chk($sformatf("timeout wait%0d stall", i), 32'(stall_pipeline), 1);
      chk($sformatf("timeout wait%0d flag", i), 32'(mem_timeout), 0);
      tick();
    end
    idle(0);
    #3;
    chk("timeout set", 32'(mem_timeout), 1);
    chk("timeout still stalled", 32'(stall_pipeline), 1);
    tick();
    idle(1);
    #3;
    chk("timeout release stall", 32'(stall_pipeline), 0);
    chk("timeout sticky at release", 32'(mem_timeout), 1);
    tick();
    idle(0);
    #3;
    chk("timeout sticky after", 32'(mem_timeout), 1);
    chk("timeout stall_count", 32'(stall_count), T_OUT + 1);
    tick();

    // reset asserted in the middle of a wait
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 12, 1, 7'h03, 1);
    tick();
    idle(0);
    tick();
    tick();
    chk("midwait stall before reset", 32'(stall_pipeline), 1);
    chk("midwait stall_count before reset", 32'(stall_count), 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midwait async stall", 32'(stall_pipeline), 0);
    chk("midwait async stall_count", 32'(stall_count), 0);
    chk("midwait async MEM_opcode", 32'(MEM_opcode), 32'h13);
    chk("midwait async timeout", 32'(mem_timeout), 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    drive(1, 0, 0, 0, 1, 1, 0, 0, 7'h33, 0);
    #3;
    chk("post reset stall", 32'(stall_pipeline), 0);
    chk("post reset mem_rd", 32'(mem_rd), 0);
    chk("post reset hazard_op", 32'(hazard_op), 0);
    chk("post reset timeout", 32'(mem_timeout), 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
